// File: rtl/soc_bal_pkg.sv
// Shared definitions for the SOC-weighted current balancer: FSM state
// encodings and width helpers derived from the block parameters.
package soc_bal_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SUM  = 2'd1;
    localparam logic [1:0] ST_DIV  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

    // Weight accumulator: N_CH full-scale weights never overflow this width.
    function automatic int sum_width(input int n_ch, input int soc_w);
        return soc_w + clog2(n_ch);
    endfunction

    // Magnitude of a signed current after saturating the most negative code.
    function automatic int mag_width(input int i_w);
        return i_w - 1;
    endfunction

    // Width of weight * |I|.
    function automatic int prod_width(input int soc_w, input int i_w);
        return soc_w + i_w - 1;
    endfunction

    // Channel index width, at least one bit.
    function automatic int ch_width(input int n_ch);
        return (clog2(n_ch) < 1) ? 1 : clog2(n_ch);
    endfunction

endpackage

// File: rtl/soc_balancer_seq_udiv.sv
// Serial unsigned restoring divider: one load cycle, then one quotient bit
// per cycle. done is asserted in the last iteration cycle and quotient is
// valid alongside it. Divisor must be non-zero.
module seq_udiv
    import soc_bal_pkg::*;
#(
    parameter int DVD_W = 39,
    parameter int DIV_W = 18
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [DVD_W-1:0] dividend,
    input  logic [DIV_W-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [DVD_W-1:0] quotient
);

    localparam int CNT_W = clog2(DVD_W + 1);

    logic [DIV_W-1:0] rem_r;
    logic [DIV_W-1:0] div_r;
    logic [DVD_W-1:0] quo_r;
    logic [CNT_W-1:0] cnt_r;
    logic             busy_r;

    logic [DIV_W:0]   rem_shift;
    logic             ge;
    logic [DIV_W-1:0] rem_next;
    logic [DVD_W-1:0] quo_next;

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    always_comb begin
        rem_shift = {rem_r, quo_r[DVD_W-1]};
        ge        = (rem_shift >= {1'b0, div_r});
        // The remainder after subtraction is below the divisor, so the low
        // DIV_W bits of the modular difference are exact.
        rem_next  = ge ? (rem_shift[DIV_W-1:0] - div_r) : rem_shift[DIV_W-1:0];
        quo_next  = {quo_r[DVD_W-2:0], ge};
    end

    // Load on start, then iterate DVD_W times.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_r  <= '0;
            div_r  <= '0;
            quo_r  <= '0;
            cnt_r  <= '0;
            busy_r <= 1'b0;
        end else if (busy_r) begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values of its neighbours, like real flops.
            rem_r <= rem_next;
            quo_r <= quo_next;
            cnt_r <= cnt_r - CNT_W'(1);
            if (cnt_r == CNT_W'(1)) busy_r <= 1'b0;
        end else if (start) begin
            rem_r  <= '0;
            div_r  <= divisor;
            quo_r  <= dividend;
            cnt_r  <= CNT_W'(DVD_W);
            busy_r <= 1'b1;
        end
    end

    assign busy     = busy_r;
    assign done     = busy_r && (cnt_r == CNT_W'(1));
    assign quotient = quo_next;

endmodule

// File: rtl/soc_balancer_seq.sv
// SOC-weighted pack current distributor. Sums per-cell weights serially,
// then divides w_k*|I| by the sum with one shared serial divider.
// Optional macro SOC_BAL_ROUND_EN: round-half-up division (one extra
// dividend bit, so one extra cycle per channel); undefined = truncation.
module soc_balancer_seq
    import soc_bal_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int SOC_W = 16,
    parameter int I_W   = 24
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [N_CH*SOC_W-1:0] soc_in,
    input  logic [I_W-1:0]        i_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [N_CH*I_W-1:0]   i_out,
    output logic                  err_den
);

    localparam int SUM_W  = sum_width(N_CH, SOC_W);
    localparam int MAG_W  = mag_width(I_W);
    localparam int PROD_W = prod_width(SOC_W, I_W);
    localparam int CH_W   = ch_width(N_CH);
`ifdef SOC_BAL_ROUND_EN
    localparam int DVD_W  = PROD_W + 1;
`else
    localparam int DVD_W  = PROD_W;
`endif
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(N_CH - 1);

    logic [1:0]            state_r;
    logic [N_CH*SOC_W-1:0] soc_r;
    logic                  sign_r;
    logic [MAG_W-1:0]      mag_r;
    logic [CH_W-1:0]       ch_r;
    logic [SUM_W-1:0]      sum_r;
    logic [N_CH*I_W-1:0]   i_out_r;
    logic                  err_r;

    logic [I_W-1:0]        abs_full;
    logic [MAG_W-1:0]      abs_in;
    logic [SOC_W-1:0]      soc_cur;
    logic [SOC_W-1:0]      w_cur;
    logic [SUM_W-1:0]      sum_next;
    logic [PROD_W-1:0]     prod;
    logic [DVD_W-1:0]      dividend;
    logic                  div_start;
    logic                  div_busy;
    logic                  div_done;
    logic [DVD_W-1:0]      div_q;
    logic [MAG_W-1:0]      q_mag;
    logic [I_W-1:0]        share;

    // Saturating magnitude of the incoming current.
    always_comb begin
        // NOTE: default first so no path leaves abs_in unassigned (no latch).
        abs_in   = abs_full[MAG_W-1:0];
        abs_full = i_in[I_W-1] ? -i_in : i_in;
        // Only the most negative code still has its top bit set here.
        if (abs_full[I_W-1]) abs_in = '1;
        else                 abs_in = abs_full[MAG_W-1:0];
    end

    // Current channel weight, running sum, and the division operands.
    always_comb begin
        soc_cur  = soc_r[ch_r*SOC_W +: SOC_W];
        // Charging weights the emptiest cells: full-scale minus SOC.
        w_cur    = sign_r ? ~soc_cur : soc_cur;
        sum_next = sum_r + SUM_W'(w_cur);
        prod     = PROD_W'(w_cur) * PROD_W'(mag_r);
`ifdef SOC_BAL_ROUND_EN
        dividend = DVD_W'(prod) + DVD_W'(sum_r >> 1);
`else
        dividend = DVD_W'(prod);
`endif
        // The clamp only matters when rounding; truncation never exceeds |I|.
        if (div_q > DVD_W'(mag_r)) q_mag = mag_r;
        else                       q_mag = div_q[MAG_W-1:0];
        share    = sign_r ? -{1'b0, q_mag} : {1'b0, q_mag};
    end

    // A new channel division starts whenever the divider is free in DIV.
    assign div_start = (state_r == ST_DIV) && !div_busy;

    seq_udiv #(
        .DVD_W (DVD_W),
        .DIV_W (SUM_W)
    ) u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (div_start),
        .dividend (dividend),
        .divisor  (sum_r),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (div_q)
    );

    // Transaction FSM: accept, sum weights, divide per channel, hold result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            soc_r   <= '0;
            sign_r  <= 1'b0;
            mag_r   <= '0;
            ch_r    <= '0;
            sum_r   <= '0;
            i_out_r <= '0;
            err_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_valid) begin
                        soc_r   <= soc_in;
                        sign_r  <= i_in[I_W-1];
                        mag_r   <= abs_in;
                        ch_r    <= '0;
                        sum_r   <= '0;
                        i_out_r <= '0;
                        err_r   <= 1'b0;
                        state_r <= (i_in == '0) ? ST_DONE : ST_SUM;
                    end
                end
                ST_SUM: begin
                    sum_r <= sum_next;
                    if (ch_r == LAST_CH) begin
                        ch_r <= '0;
                        if (sum_next == '0) begin
                            err_r   <= 1'b1;
                            state_r <= ST_DONE;
                        end else begin
                            state_r <= ST_DIV;
                        end
                    end else begin
                        ch_r <= ch_r + CH_W'(1);
                    end
                end
                ST_DIV: begin
                    if (div_done) begin
                        i_out_r[ch_r*I_W +: I_W] <= share;
                        if (ch_r == LAST_CH) begin
                            ch_r    <= '0;
                            state_r <= ST_DONE;
                        end else begin
                            ch_r <= ch_r + CH_W'(1);
                        end
                    end
                end
                ST_DONE: begin
                    if (out_ready) state_r <= ST_IDLE;
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = (state_r == ST_IDLE);
    assign out_valid = (state_r == ST_DONE);
    assign i_out     = i_out_r;
    assign err_den   = err_r;

endmodule

// File: tb/tb_soc_balancer_seq.sv
// Self-checking bench for soc_balancer_seq: directed scenarios plus random
// transactions, compared against an arithmetic reference model.
module tb_soc_balancer_seq;

    localparam int N_CH   = 4;
    localparam int SOC_W  = 16;
    localparam int I_W    = 24;
    localparam int PROD_W = SOC_W + I_W - 1;
`ifdef SOC_BAL_ROUND_EN
    localparam int CH_CYC = PROD_W + 2;
`else
    localparam int CH_CYC = PROD_W + 1;
`endif
    localparam longint FS      = (longint'(1) << SOC_W) - 1;
    localparam longint MAX_MAG = (longint'(1) << (I_W - 1)) - 1;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  in_valid = 1'b0;
    logic                  in_ready;
    logic [N_CH*SOC_W-1:0] soc_in = '0;
    logic [I_W-1:0]        i_in = '0;
    logic                  out_valid;
    logic                  out_ready = 1'b0;
    logic [N_CH*I_W-1:0]   i_out;
    logic                  err_den;

    int n_checks = 0;
    int n_errors = 0;

    soc_balancer_seq #(.N_CH(N_CH), .SOC_W(SOC_W), .I_W(I_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .soc_in    (soc_in),
        .i_in      (i_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .i_out     (i_out),
        .err_den   (err_den)
    );

    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // Reference: shares from the weighting rule with 64-bit integer arithmetic.
    function automatic void model(input logic [N_CH*SOC_W-1:0] soc, input logic [I_W-1:0] i_raw,
                                  output logic [N_CH*I_W-1:0] exp_vec, output logic exp_err,
                                  output int exp_lat);
        longint iv, mag, sum, q;
        longint w [N_CH];
        bit neg;
        iv  = longint'($signed(i_raw));
        neg = (iv < 0);
        mag = neg ? -iv : iv;
        if (mag > MAX_MAG) mag = MAX_MAG;
        sum = 0;
        for (int k = 0; k < N_CH; k++) begin
            w[k] = neg ? FS - longint'(soc[k*SOC_W +: SOC_W]) : longint'(soc[k*SOC_W +: SOC_W]);
            sum += w[k];
        end
        exp_vec = '0;
        exp_err = 1'b0;
        if (iv == 0) begin
            exp_lat = 1;
        end else if (sum == 0) begin
            exp_err = 1'b1;
            exp_lat = 1 + N_CH;
        end else begin
            exp_lat = 1 + N_CH + N_CH * CH_CYC;
            for (int k = 0; k < N_CH; k++) begin
`ifdef SOC_BAL_ROUND_EN
                q = (w[k] * mag + sum / 2) / sum;
                if (q > mag) q = mag;
`else
                q = (w[k] * mag) / sum;
`endif
                exp_vec[k*I_W +: I_W] = I_W'(neg ? -q : q);
            end
        end
    endfunction

    // Drive one request and wait for out_valid; latency counts edges from accept.
    task automatic run_txn(input logic [N_CH*SOC_W-1:0] soc, input logic [I_W-1:0] i_val,
                           output int lat, output int wait_cyc, output bit timeout);
        @(negedge clk);
        in_valid = 1'b1;
        soc_in   = soc;
        i_in     = i_val;
        wait_cyc = 0;
        timeout  = 1'b0;
        while (!in_ready && wait_cyc < 500) begin
            @(negedge clk);
            wait_cyc++;
        end
        if (!in_ready) timeout = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 3000) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!out_valid) timeout = 1'b1;
    endtask

    task automatic release_out();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    // Full transaction compared against the model, including the out handshake.
    task automatic test_vector(input string name, input logic [N_CH*SOC_W-1:0] soc,
                               input logic [I_W-1:0] i_val, output int lat, output int wait_cyc);
        logic [N_CH*I_W-1:0] exp_vec;
        logic exp_err;
        int   exp_lat;
        bit   to;
        model(soc, i_val, exp_vec, exp_err, exp_lat);
        run_txn(soc, i_val, lat, wait_cyc, to);
        n_checks++;
        if (to) begin
            n_errors++;
            $display("FAIL %s timeout: lat=%0d wait=%0d", name, lat, wait_cyc);
        end
        n_checks++;
        if (lat != exp_lat) begin
            n_errors++;
            $display("FAIL %s latency got=%0d expected=%0d", name, lat, exp_lat);
        end
        n_checks++;
        if (err_den !== exp_err) begin
            n_errors++;
            $display("FAIL %s err_den got=%b expected=%b", name, err_den, exp_err);
        end
        for (int k = 0; k < N_CH; k++) begin
            n_checks++;
            if (i_out[k*I_W +: I_W] !== exp_vec[k*I_W +: I_W]) begin
                n_errors++;
                $display("FAIL %s ch%0d i_out got=%0d expected=%0d", name, k,
                         $signed(i_out[k*I_W +: I_W]), $signed(exp_vec[k*I_W +: I_W]));
            end
        end
        release_out();
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL %s after handshake out_valid=%b in_ready=%b expected 0/1",
                     name, out_valid, in_ready);
        end
    endtask

    task automatic test_reset();
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || i_out !== '0 || err_den !== 1'b0) begin
            n_errors++;
            $display("FAIL reset in_ready=%b out_valid=%b i_out=%h err_den=%b expected 1/0/0/0",
                     in_ready, out_valid, i_out, err_den);
        end
    endtask

    task automatic test_equal_split();
        int lat, wc;
        test_vector("equal_split", {N_CH{16'd32768}}, 24'd1000, lat, wc);
        for (int k = 0; k < N_CH; k++) begin
            n_checks++;
            if ($signed(i_out[k*I_W +: I_W]) !== 250) begin
                n_errors++;
                $display("FAIL equal_split ch%0d literal got=%0d expected=250", k,
                         $signed(i_out[k*I_W +: I_W]));
            end
        end
        n_checks++;
`ifdef SOC_BAL_ROUND_EN
        if (lat != 169) begin
            n_errors++;
            $display("FAIL equal_split latency literal got=%0d expected=169", lat);
        end
`else
        if (lat != 165) begin
            n_errors++;
            $display("FAIL equal_split latency literal got=%0d expected=165", lat);
        end
`endif
    endtask

    task automatic test_mixed_charge();
        int lat, wc;
        logic [N_CH*I_W-1:0] lit;
`ifdef SOC_BAL_ROUND_EN
        lit = {I_W'(-300), I_W'(-300), I_W'(-600), I_W'(0)};
`else
        lit = {I_W'(-300), I_W'(-299), I_W'(-600), I_W'(0)};
`endif
        test_vector("mixed_charge", {16'd32767, 16'd32768, 16'd0, 16'd65535}, I_W'(-1200), lat, wc);
        n_checks++;
        if (i_out !== lit) begin
            n_errors++;
            $display("FAIL mixed_charge literal got=%h expected=%h", i_out, lit);
        end
    endtask

    task automatic test_zero_cases();
        int lat, wc;
        test_vector("zero_current", {16'd1234, 16'd65535, 16'd0, 16'd777}, 24'd0, lat, wc);
        test_vector("zero_sum_dis", '0, 24'd500, lat, wc);
        test_vector("zero_sum_chg", '1, I_W'(-3), lat, wc);
    endtask

    task automatic test_min_current();
        int lat, wc;
        int exp_share;
`ifdef SOC_BAL_ROUND_EN
        exp_share = -2097152;
`else
        exp_share = -2097151;
`endif
        test_vector("min_current", {N_CH{16'd40000}}, 24'h800000, lat, wc);
        for (int k = 0; k < N_CH; k++) begin
            n_checks++;
            if ($signed(i_out[k*I_W +: I_W]) !== exp_share) begin
                n_errors++;
                $display("FAIL min_current ch%0d got=%0d expected=%0d", k,
                         $signed(i_out[k*I_W +: I_W]), exp_share);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [N_CH*SOC_W-1:0] soc;
        logic [N_CH*I_W-1:0]   exp_vec;
        logic exp_err;
        int   exp_lat, lat, wc;
        bit   to;
        soc = {16'd100, 16'd20000, 16'd45000, 16'd9};
        model(soc, 24'd777, exp_vec, exp_err, exp_lat);
        run_txn(soc, 24'd777, lat, wc, to);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            in_valid = 1'b1;
            soc_in   = N_CH*SOC_W'($urandom());
            i_in     = 24'd5;
            @(posedge clk);
            #1;
            n_checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || i_out !== exp_vec || err_den !== exp_err) begin
                n_errors++;
                $display("FAIL backpressure cycle %0d out_valid=%b in_ready=%b i_out=%h expected 1/0/%h",
                         c, out_valid, in_ready, i_out, exp_vec);
            end
        end
        in_valid = 1'b0;
        release_out();
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL backpressure release in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
        end
        test_vector("after_release", {16'd5000, 16'd6000, 16'd7000, 16'd8000}, I_W'(-4321), lat, wc);
        n_checks++;
        if (wc != 0) begin
            n_errors++;
            $display("FAIL after_release accept wait got=%0d expected=0", wc);
        end
    endtask

    task automatic test_reset_mid_div();
        int lat, wc;
        @(negedge clk);
        in_valid = 1'b1;
        soc_in   = {16'd1000, 16'd2000, 16'd3000, 16'd4000};
        i_in     = 24'd99999;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (79) @(posedge clk);
        #1;
        n_checks++;
        if (in_ready !== 1'b0 || i_out === '0) begin
            n_errors++;
            $display("FAIL reset_mid_div busy check in_ready=%b i_out=%h expected 0/nonzero", in_ready, i_out);
        end
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || i_out !== '0 || err_den !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_mid_div in_ready=%b out_valid=%b i_out=%h err_den=%b expected 1/0/0/0",
                     in_ready, out_valid, i_out, err_den);
        end
        @(negedge clk);
        rst = 1'b0;
        test_vector("post_reset", {16'd12345, 16'd54321, 16'd1, 16'd65000}, 24'd3000000, lat, wc);
    endtask

    task automatic test_random();
        logic [N_CH*SOC_W-1:0] soc;
        logic [I_W-1:0]        iv;
        int lat, wc, r;
        for (int t = 0; t < 24; t++) begin
            for (int k = 0; k < N_CH; k++) begin
                r = $urandom_range(0, 7);
                if (r == 0)      soc[k*SOC_W +: SOC_W] = '0;
                else if (r == 1) soc[k*SOC_W +: SOC_W] = '1;
                else             soc[k*SOC_W +: SOC_W] = SOC_W'($urandom_range(0, 65535));
            end
            r = $urandom_range(0, 9);
            if (r == 0)      iv = '0;
            else if (r == 1) iv = 24'h800000;
            else if (r == 2) iv = 24'h7fffff;
            else             iv = I_W'($urandom());
            test_vector("random", soc, iv, lat, wc);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        test_reset();
        rst = 1'b0;
        @(negedge clk);
        test_reset();
        test_equal_split();
        test_mixed_charge();
        test_zero_cases();
        test_min_current();
        test_backpressure();
        test_reset_mid_div();
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
